// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: UART transmitter with a parametrised payload width and a
// small input FIFO. One bit per clk cycle, LSB first, optional parity bit,
// one or two stop bits, back-to-back frames when words are queued.
module uart_tx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  Ser_Done,
  output logic                  fifo_full,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity of a payload word; odd selects odd parity.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
    calc_parity = odd ? ~(^data) : (^data);
  endfunction

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  r_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_has_data;
  logic [DATA_WIDTH-1:0] w_head;

  // Frame engine state
  state_t                r_state;
  state_t                w_state_nxt;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic                  r_stop_cnt;
  logic                  w_stop_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // Per-frame configuration captured when the word is popped
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_stop2;

  // Registered outputs and their next values
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  // A full FIFO refuses the write even if a pop happens on the same edge.
  assign w_push     = Data_Valid & ~r_full;
  assign w_has_data = (r_count != CNT_W'(0));
  assign w_head     = r_mem[r_rd_ptr];

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= P_DATA;
    end
  end

  // FIFO pointers, occupancy, full flag and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_ovf   <= Data_Valid & r_full;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being
  // entered so that TX_OUT/busy/Ser_Done can be registered with the state.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_nxt      = r_bit;
    w_stop_cnt_nxt = r_stop_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = 1'b1;
    w_busy_nxt     = 1'b1;
    w_done_nxt     = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_has_data) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      S_START: begin
        w_state_nxt = S_DATA;
        w_bit_nxt   = BIT_W'(0);
        w_tx_nxt    = r_shift[0];
      end
      S_DATA: begin
        if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
          w_stop_cnt_nxt = 1'b0;
          if (r_par_en) begin
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par_bit;
          end else begin
            w_state_nxt = S_STOP;
            w_done_nxt  = ~r_stop2;
          end
        end else begin
          w_bit_nxt   = r_bit + BIT_W'(1);
          w_shift_nxt = r_shift >> 1;
          w_tx_nxt    = r_shift[1];
        end
      end
      S_PARITY: begin
        w_state_nxt    = S_STOP;
        w_stop_cnt_nxt = 1'b0;
        w_done_nxt     = ~r_stop2;
      end
      S_STOP: begin
        if (r_stop2 && !r_stop_cnt) begin
          w_stop_cnt_nxt = 1'b1;
          w_done_nxt     = 1'b1;
        end else if (w_has_data) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Frame engine registers, frame configuration capture and line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit      <= BIT_W'(0);
      r_stop_cnt <= 1'b0;
      r_shift    <= DATA_WIDTH'(0);
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit      <= w_bit_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_shift    <= w_shift_nxt;
      if (w_pop) begin
        r_par_en  <= PAR_EN;
        r_par_bit <= calc_parity(w_head, PAR_TYP);
        r_stop2   <= STOP2;
      end
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign TX_OUT     = r_tx;
  assign busy       = r_busy;
  assign Ser_Done   = r_done;
  assign fifo_full  = r_full;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: scoreboard bench for uart_tx_fifo_param. Expected
// frames are queued as words are written and compared as frames leave TX_OUT.
module tb_uart_tx_fifo_param;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [7:0]    p_data;
  logic          dv, par_en, par_typ, stop2;
  logic          tx, busy, done, full, ovf;
  logic [CW-1:0] cnt;

  logic [4:0]    p5;
  logic [8:0]    p9;
  logic          dv5, dv9, sw_pe, sw_zero;
  logic          tx5, busy5, done5, full5, ovf5;
  logic          tx9, busy9, done9, full9, ovf9;
  logic [CW-1:0] cnt5, cnt9;

  uart_tx_fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .P_DATA(p_data), .Data_Valid(dv),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx), .busy(busy), .Ser_Done(done), .fifo_full(full),
    .fifo_count(cnt), .overflow(ovf));

  uart_tx_fifo_param #(.DATA_WIDTH(5), .FIFO_DEPTH(DEPTH)) u_dut5 (
    .clk(clk), .rst(rst), .P_DATA(p5), .Data_Valid(dv5),
    .PAR_EN(sw_pe), .PAR_TYP(sw_zero), .STOP2(sw_zero),
    .TX_OUT(tx5), .busy(busy5), .Ser_Done(done5), .fifo_full(full5),
    .fifo_count(cnt5), .overflow(ovf5));

  uart_tx_fifo_param #(.DATA_WIDTH(9), .FIFO_DEPTH(DEPTH)) u_dut9 (
    .clk(clk), .rst(rst), .P_DATA(p9), .Data_Valid(dv9),
    .PAR_EN(sw_pe), .PAR_TYP(sw_zero), .STOP2(sw_zero),
    .TX_OUT(tx9), .busy(busy9), .Ser_Done(done9), .fifo_full(full9),
    .fifo_count(cnt9), .overflow(ovf9));

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       s2;
  } sb_item_t;

  sb_item_t sb_q[$];
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits (bit i = i-th transmitted bit) for one 8-bit frame.
  function automatic void exp_frame(input sb_item_t it, output logic [31:0] bits, output int len);
    bits = 32'h0;
    for (int i = 0; i < 8; i++) bits[1 + i] = it.data[i];
    len = 9;
    if (it.pe) begin
      bits[len] = it.pt ? ~(^it.data) : (^it.data);
      len++;
    end
    bits[len] = 1'b1;
    len++;
    if (it.s2) begin
      bits[len] = 1'b1;
      len++;
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic [7:0] d);
    p_data = d;
    dv     = 1'b1;
    sb_q.push_back('{data: d, pe: par_en, pt: par_typ, s2: stop2});
  endtask

  // Monitor: collects each frame from the main DUT and measures busy runs.
  logic        in_frame = 1'b0;
  int          idx = 0;
  int          exp_len = 0;
  logic [31:0] exp_bits, obs_bits, obs_done;
  int          run_len = 0;
  int          last_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      run_len  = 0;
    end else begin
      if (busy) run_len++;
      else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (!in_frame && busy) begin
        check_val("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'h1);
        if (sb_q.size() != 0) begin
          exp_frame(sb_q.pop_front(), exp_bits, exp_len);
          in_frame = 1'b1;
          idx      = 0;
          obs_bits = 32'h0;
          obs_done = 32'h0;
        end
      end
      if (in_frame) begin
        obs_bits[idx] = tx;
        obs_done[idx] = done;
        idx++;
        if (idx == exp_len) begin
          check_val("frame_bits", obs_bits, exp_bits);
          check_val("ser_done", obs_done, 32'h1 << (exp_len - 1));
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle;
    int k;
    k = 0;
    while ((busy || cnt != '0) && k < 300) begin
      tick;
      k++;
    end
    @(negedge clk);
    #1;
    check_val("idle_reached", {30'b0, busy, cnt != '0}, 32'h0);
  endtask

  task automatic sweep_frame(input int w, input logic pe, output logic [31:0] bits, output int len);
    sw_pe = pe;
    if (w == 5) begin p5 = 5'h1F; dv5 = 1'b1; end
    else        begin p9 = 9'h1FF; dv9 = 1'b1; end
    tick;
    dv5 = 1'b0;
    dv9 = 1'b0;
    bits = 32'h0;
    len  = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if ((w == 5) ? busy5 : busy9) begin
        bits[len] = (w == 5) ? tx5 : tx9;
        len++;
      end else if (len > 0) begin
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          max_cnt;
    int          ovf_hits;
    logic        busy_seen;
    logic [31:0] sbits;
    int          slen;
    int          widths [2];

    rst = 1'b1; dv = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    dv5 = 1'b0; dv9 = 1'b0; p5 = 5'h00; p9 = 9'h000; sw_pe = 1'b0; sw_zero = 1'b0;
    tick;
    tick;
    check_val("rst_tx", tx, 32'h1);
    check_val("rst_busy", busy, 32'h0);
    check_val("rst_done", done, 32'h0);
    check_val("rst_full", full, 32'h0);
    check_val("rst_count", cnt, 32'h0);
    check_val("rst_ovf", ovf, 32'h0);
    rst = 1'b0;

    // Single frame 0xA5, even parity, one stop bit
    par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0;
    push_item(8'hA5);
    tick;
    dv = 1'b0;
    check_val("lat_tx_n", tx, 32'h1);
    check_val("lat_busy_n", busy, 32'h0);
    check_val("lat_cnt_n", cnt, 32'h1);
    tick;
    check_val("lat_tx_n1", tx, 32'h0);
    check_val("lat_busy_n1", busy, 32'h1);
    check_val("lat_cnt_n1", cnt, 32'h0);
    wait_idle;
    check_val("busy_len_single", last_run, 32'd11);

    // Odd parity, two stops; configuration changed mid-frame
    par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1;
    push_item(8'hA5);
    tick;
    dv = 1'b0;
    repeat (4) tick;
    par_typ = 1'b0; stop2 = 1'b0; par_en = 1'b0;
    wait_idle;
    check_val("busy_len_odd2", last_run, 32'd12);

    // Burst of four back-to-back words
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    max_cnt = 0;
    ovf_hits = 0;
    for (int i = 0; i < 4; i++) begin
      push_item(8'(i + 1));
      tick;
      if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
      ovf_hits += int'(ovf);
    end
    dv = 1'b0;
    check_val("burst_cnt_peak", max_cnt, 32'd3);
    check_val("burst_ovf", ovf_hits, 32'd0);
    wait_idle;
    check_val("busy_len_burst", last_run, 32'd40);

    // Overflow: one frame in flight, then six writes into a four-deep FIFO
    push_item(8'h11);
    tick;
    dv = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 6; i++) begin
      p_data = 8'(8'h20 + i);
      dv = 1'b1;
      if (i < 4) sb_q.push_back('{data: 8'(8'h20 + i), pe: par_en, pt: par_typ, s2: stop2});
      tick;
      if (i < 4) begin
        check_val($sformatf("ovf_cnt_%0d", i), cnt, 32'(i + 1));
        check_val($sformatf("ovf_full_%0d", i), full, (i == 3) ? 32'h1 : 32'h0);
        check_val($sformatf("ovf_pulse_%0d", i), ovf, 32'h0);
      end else begin
        check_val($sformatf("ovf_cnt_%0d", i), cnt, 32'd4);
        check_val($sformatf("ovf_pulse_%0d", i), ovf, 32'h1);
      end
    end
    dv = 1'b0;
    tick;
    check_val("ovf_pulse_end", ovf, 32'h0);
    wait_idle;
    check_val("ovf_full_drained", full, 32'h0);

    // Reset during DATA bit 3 with two words queued
    for (int i = 0; i < 3; i++) begin
      push_item(8'(8'h40 + i));
      tick;
    end
    dv = 1'b0;
    check_val("rst_pre_cnt", cnt, 32'd2);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    check_val("mid_rst_tx", tx, 32'h1);
    check_val("mid_rst_busy", busy, 32'h0);
    check_val("mid_rst_cnt", cnt, 32'h0);
    check_val("mid_rst_full", full, 32'h0);
    tick;
    sb_q.delete();
    rst = 1'b0;
    busy_seen = 1'b0;
    repeat (30) begin
      tick;
      busy_seen = busy_seen | busy;
    end
    check_val("no_frame_after_rst", busy_seen, 32'h0);
    check_val("line_idle_after_rst", tx, 32'h1);

    // Width sweep with all-ones payloads; parity (even) is 1 in both widths
    widths[0] = 5;
    widths[1] = 9;
    for (int wi = 0; wi < 2; wi++) begin
      for (int pe = 0; pe < 2; pe++) begin
        sweep_frame(widths[wi], 1'(pe), sbits, slen);
        check_val($sformatf("sweep_len_w%0d_pe%0d", widths[wi], pe), slen, 32'(widths[wi] + pe + 2));
        check_val($sformatf("sweep_bits_w%0d_pe%0d", widths[wi], pe), sbits,
                  ((32'h1 << (widths[wi] + pe + 2)) - 32'h1) & ~32'h1);
      end
    end

    check_val("sb_drained", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
